cgra_tile_config_decoder: RTL and testbench
===========================================

// Module: cgra_tile_config_decoder
// PURPOSE
//  Receive end of the CGRA config bus: the tile-side responder to the (config_addr_in, config_data_in) word stream driven one word per cycle.
//  Registers and decodes each word, fans out write strobes to this tile's features and keeps a shadow register file for readback.
//  Tracks load progress and flags config_done_out once the stream goes idle.
// PARAMETERS
//  TILE_ID       16'h0001  this tile's id; 0 is reserved (no-op address), never a valid TILE_ID
//  NUM_FEATURES  4         feature slots in tile (1..16)
//  NUM_REGS      8         config regs per feature (1..16)
//  IDLE_LIMIT    4         consecutive no-op cycles ending a load (>=1)
// PORTS
//  clk_in                 in   1   clock; all state on rising edge
//  reset_in               in   1   synchronous, active-high reset
//  config_addr_in         in   32  [15:0] tile id, [23:16] feature id, [31:24] reg id; 32'h0 = no-op
//  config_data_in         in   32  write data paired with config_addr_in
//  read_req_in            in   1   readback request, single-cycle pulse
//  read_addr_in           in   32  readback address, same field layout
//  feature_we_out         out  NUM_FEATURES  one-hot write strobe
//  feature_reg_out        out  8   register id for strobed feature
//  feature_data_out       out  32  write data for strobed feature
//  read_valid_out         out  1   readback data valid
//  read_data_out          out  32  readback data
//  read_err_out           out  1   readback address not in this tile / out of range
//  config_done_out        out  1   load complete
//  write_count_out        out  16  accepted writes since last reset (saturating)
// BEHAVIOUR
//  Reset: every output 0, shadow RF all 0, FSM=S_WAIT, idle count 0.
//  Stage 1 (cycle N): register addr/data unconditionally.
//  Stage 2 (cycle N+1): decode. Hit = tile==TILE_ID && feat<NUM_FEATURES && reg<NUM_REGS.
//   On hit: feature_we_out[feat]=1 for exactly one cycle; feature_reg_out/feature_data_out valid that cycle; shadow RF written; write_count_out+1 (holds at 16'hFFFF).
//   Miss (other tile, out-of-range field, addr 0): no strobe; reg/data outputs hold their last values.
//   Latency: word on pins at edge N -> strobe high after edge N+1.
//  Readback: req at edge N -> read_valid_out=1 for one cycle after edge N+1.
//   Read-before-write: a read colliding with a stage-2 write to the same register returns the old value.
//   Miss: read_data_out=0, read_err_out=1. Without a request, read_valid_out=0 and read_err_out=0.
//  FSM (evaluated on stage-1 registered address):
//   S_WAIT -> S_LOAD on the first non-zero address; idle count 0.
//   S_LOAD: non-zero address clears idle count; zero increments it.
//    Count reaching IDLE_LIMIT -> S_DONE, config_done_out=1 from that edge.
//   S_DONE: non-zero address -> S_LOAD, config_done_out=0 from the same edge (reconfiguration).
//    Shadow RF and write_count_out are kept across reconfiguration.
//   Non-zero words for other tiles count as activity (bus busy), not idle.
//  reset_in mid-load: cancels the pending stage-2 write (no strobe next cycle) and restores reset values.
// STRUCTURE
//  cgra_config_pkg:
//   field LSB/width localparams (TILE 0/16, FEAT 16/8, REG 24/8), CFG_NOP=32'h0
//   FSM enum {S_WAIT, S_LOAD, S_DONE}
//  Sub-module cgra_config_shadow_rf: NUM_FEATURES*NUM_REGS x 32
//   1 sync write port; 1 registered read port, read-before-write
//  Top holds stage-1 regs, decode, FSM, counters.
// TESTING
//  1. Reset, write 32'h0301_0001 data 32'hDEAD_BEEF
//     -> feature_we_out=4'b0010, feature_reg_out=3, feature_data_out=32'hDEADBEEF two edges after drive; write_count_out=1.
//  2. Write to tile 2 (32'h0000_0002), feat 4 (32'h0004_0001), reg 8 (32'h0800_0001)
//     -> no strobe, write_count_out unchanged, FSM in S_LOAD.
//  3. Three writes then 4 no-ops -> config_done_out rises after the 4th no-op is registered;
//     one more write 32'h0000_0001 -> done falls on the next edge.
//  4. Readback of 32'h0301_0001 after test 1 -> read_valid_out=1, read_data_out=32'hDEADBEEF, err=0;
//     read of 32'h0000_0005 -> data 0, err=1.
//  5. Same-cycle write 32'h1 and read of 32'h0000_0001 (feat0 reg0, prior 0x0) -> read returns 0x0; a following read returns 0x1.
//  6. Assert reset_in the cycle after driving a hit word -> no strobe; all outputs 0; write_count_out=0.

Source files
------------

// File: rtl/cgra_config_pkg.sv
// Shared field layout, no-op word and load FSM states
// for the CGRA tile configuration decoder.
package cgra_config_pkg;

    localparam int TILE_LSB = 0;
    localparam int TILE_W   = 16;
    localparam int FEAT_LSB = 16;
    localparam int FEAT_W   = 8;
    localparam int REG_LSB  = 24;
    localparam int REG_W    = 8;

    localparam logic [31:0] CFG_NOP = 32'h0;

    typedef enum logic [1:0] {
        S_WAIT,
        S_LOAD,
        S_DONE
    } cfg_state_e;

    // Bit order matches the bus word: reg[31:24], feat[23:16], tile[15:0]
    typedef struct packed {
        logic [REG_W-1:0]  reg_id;
        logic [FEAT_W-1:0] feat;
        logic [TILE_W-1:0] tile;
    } cfg_addr_t;

endpackage

// File: rtl/cgra_config_shadow_rf.sv
// Shadow copy of every config register in the tile, one sync write
// port and one registered read-before-write read port.
module cgra_config_shadow_rf
    import cgra_config_pkg::*;
#(
    parameter int NUM_FEATURES = 4,
    parameter int NUM_REGS     = 8,
    parameter int DEPTH        = NUM_FEATURES * NUM_REGS,
    parameter int AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_in,
    input  logic          reset_in,
    input  logic          we_in,
    input  logic [AW-1:0] waddr_in,
    input  logic [31:0]   wdata_in,
    input  logic          re_in,
    input  logic [AW-1:0] raddr_in,
    output logic [31:0]   rdata_out
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata_out <= '0;
        end else begin
            if (we_in) begin
                mem[waddr_in] <= wdata_in;
            end
            // Reads sample the array before this edge's write lands
            if (re_in) begin
                rdata_out <= mem[raddr_in];
            end
        end
    end

endmodule

// File: rtl/cgra_tile_config_decoder.sv
// Tile-side receiver of the CGRA config bus: registers each word, decodes
// it into feature write strobes, keeps a shadow RF and tracks load progress.
module cgra_tile_config_decoder
    import cgra_config_pkg::*;
#(
    parameter logic [15:0] TILE_ID      = 16'h0001,
    parameter int          NUM_FEATURES = 4,
    parameter int          NUM_REGS     = 8,
    parameter int          IDLE_LIMIT   = 4
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic [31:0]             config_addr_in,
    input  logic [31:0]             config_data_in,
    input  logic                    read_req_in,
    input  logic [31:0]             read_addr_in,
    output logic [NUM_FEATURES-1:0] feature_we_out,
    output logic [7:0]              feature_reg_out,
    output logic [31:0]             feature_data_out,
    output logic                    read_valid_out,
    output logic [31:0]             read_data_out,
    output logic                    read_err_out,
    output logic                    config_done_out,
    output logic [15:0]             write_count_out
);

    localparam int DEPTH = NUM_FEATURES * NUM_REGS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [7:0]  NF_L   = 8'(NUM_FEATURES);
    localparam logic [7:0]  NR_L   = 8'(NUM_REGS);
    localparam logic [15:0] IDLE_L = 16'(IDLE_LIMIT);

    function automatic logic addr_hit(cfg_addr_t a);
        return (a.tile == TILE_ID) && (a.feat < NF_L) && (a.reg_id < NR_L);
    endfunction

    function automatic logic [AW-1:0] rf_index(cfg_addr_t a);
        logic [31:0] i;
        i = 32'(a.feat) * 32'(NUM_REGS) + 32'(a.reg_id);
        return i[AW-1:0];
    endfunction

    cfg_addr_t   s1_addr;
    cfg_addr_t   s1_raddr;
    logic [31:0] s1_data;
    logic        s1_rreq;

    logic                    wr_hit;
    logic                    rd_hit;
    logic                    rd_ok;
    logic [NUM_FEATURES-1:0] we_next;
    logic [31:0]             rf_rdata;

    cfg_state_e  state;
    cfg_state_e  state_nx;
    logic [15:0] idle_cnt;
    logic [15:0] idle_nx;
    logic        busy;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            s1_addr  <= '0;
            s1_raddr <= '0;
            s1_data  <= '0;
            s1_rreq  <= 1'b0;
        end else begin
            s1_addr  <= cfg_addr_t'(config_addr_in);
            s1_raddr <= cfg_addr_t'(read_addr_in);
            s1_data  <= config_data_in;
            s1_rreq  <= read_req_in;
        end
    end

    assign wr_hit = addr_hit(s1_addr);
    assign rd_hit = addr_hit(s1_raddr);

    always_comb begin
        we_next = '0;
        for (int f = 0; f < NUM_FEATURES; f++) begin
            we_next[f] = wr_hit && (s1_addr.feat == 8'(f));
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            feature_we_out   <= '0;
            feature_reg_out  <= '0;
            feature_data_out <= '0;
            write_count_out  <= '0;
            read_valid_out   <= 1'b0;
            read_err_out     <= 1'b0;
            rd_ok            <= 1'b0;
        end else begin
            feature_we_out <= we_next;
            if (wr_hit) begin
                feature_reg_out  <= s1_addr.reg_id;
                feature_data_out <= s1_data;
                if (write_count_out != 16'hFFFF) begin
                    write_count_out <= write_count_out + 16'd1;
                end
            end
            read_valid_out <= s1_rreq;
            read_err_out   <= s1_rreq && !rd_hit;
            rd_ok          <= s1_rreq && rd_hit;
        end
    end

    assign read_data_out = rd_ok ? rf_rdata : 32'h0;

    cgra_config_shadow_rf #(
        .NUM_FEATURES (NUM_FEATURES),
        .NUM_REGS     (NUM_REGS),
        .DEPTH        (DEPTH),
        .AW           (AW)
    ) u_shadow_rf (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .we_in     (wr_hit),
        .waddr_in  (rf_index(s1_addr)),
        .wdata_in  (s1_data),
        .re_in     (s1_rreq && rd_hit),
        .raddr_in  (rf_index(s1_raddr)),
        .rdata_out (rf_rdata)
    );

    // Any non-zero word, even for another tile, means the bus is still busy
    assign busy = (s1_addr != cfg_addr_t'(CFG_NOP));

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state    <= S_WAIT;
            idle_cnt <= '0;
        end else begin
            state    <= state_nx;
            idle_cnt <= idle_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idle_nx  = idle_cnt;
        unique case (state)
            S_WAIT: begin
                if (busy) begin
                    state_nx = S_LOAD;
                    idle_nx  = '0;
                end
            end
            S_LOAD: begin
                if (busy) begin
                    idle_nx = '0;
                end else if (idle_cnt + 16'd1 >= IDLE_L) begin
                    state_nx = S_DONE;
                    idle_nx  = '0;
                end else begin
                    idle_nx = idle_cnt + 16'd1;
                end
            end
            S_DONE: begin
                if (busy) begin
                    state_nx = S_LOAD;
                    idle_nx  = '0;
                end
            end
            default: begin
                state_nx = S_WAIT;
                idle_nx  = '0;
            end
        endcase
    end

    assign config_done_out = (state == S_DONE);

endmodule

// File: tb/tb_cgra_tile_config_decoder.sv
// Table-driven scoreboard bench for cgra_tile_config_decoder; every
// output is checked two edges after its word is driven.
module tb_cgra_tile_config_decoder;

    typedef struct packed {
        logic [3:0]  we;
        logic [7:0]  rg;
        logic [31:0] dt;
        logic        rv;
        logic [31:0] rd;
        logic        re;
        logic        dn;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rreq;
        logic [31:0] raddr;
        exp_t        e;
    } vec_t;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [31:0] config_addr_in;
    logic [31:0] config_data_in;
    logic        read_req_in;
    logic [31:0] read_addr_in;
    logic [3:0]  feature_we_out;
    logic [7:0]  feature_reg_out;
    logic [31:0] feature_data_out;
    logic        read_valid_out;
    logic [31:0] read_data_out;
    logic        read_err_out;
    logic        config_done_out;
    logic [15:0] write_count_out;

    int   nvec = 0;
    int   nmis = 0;
    vec_t vecs[$];
    exp_t sb[$];
    int   sb_id[$];
    exp_t zero_e;

    always #5 clk_in = ~clk_in;

    cgra_tile_config_decoder dut (
        .clk_in           (clk_in),
        .reset_in         (reset_in),
        .config_addr_in   (config_addr_in),
        .config_data_in   (config_data_in),
        .read_req_in      (read_req_in),
        .read_addr_in     (read_addr_in),
        .feature_we_out   (feature_we_out),
        .feature_reg_out  (feature_reg_out),
        .feature_data_out (feature_data_out),
        .read_valid_out   (read_valid_out),
        .read_data_out    (read_data_out),
        .read_err_out     (read_err_out),
        .config_done_out  (config_done_out),
        .write_count_out  (write_count_out)
    );

    task automatic add(
        input logic [31:0] a, input logic [31:0] d,
        input logic rq, input logic [31:0] ra,
        input logic [3:0] we, input logic [7:0] rg,
        input logic [31:0] dt, input logic rv,
        input logic [31:0] rd, input logic re,
        input logic dn, input logic [15:0] cnt
    );
        vec_t v;
        v.addr  = a;
        v.data  = d;
        v.rreq  = rq;
        v.raddr = ra;
        v.e     = '{we, rg, dt, rv, rd, re, dn, cnt};
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input exp_t e);
        nvec++;
        if (feature_we_out !== e.we || feature_reg_out !== e.rg ||
            feature_data_out !== e.dt || read_valid_out !== e.rv ||
            read_data_out !== e.rd || read_err_out !== e.re ||
            config_done_out !== e.dn || write_count_out !== e.cnt) begin
            nmis++;
            $display("FAIL %s: got we=%b reg=%0h data=%h rv=%b rd=%h err=%b done=%b cnt=%0d; want we=%b reg=%0h data=%h rv=%b rd=%h err=%b done=%b cnt=%0d",
                nm, feature_we_out, feature_reg_out, feature_data_out,
                read_valid_out, read_data_out, read_err_out,
                config_done_out, write_count_out,
                e.we, e.rg, e.dt, e.rv, e.rd, e.re, e.dn, e.cnt);
        end
    endtask

    task automatic drive(
        input logic [31:0] a, input logic [31:0] d,
        input logic rq, input logic [31:0] ra
    );
        config_addr_in = a;
        config_data_in = d;
        read_req_in    = rq;
        read_addr_in   = ra;
    endtask

    initial begin
        exp_t e;
        zero_e = '0;

        //   addr          data          rq  raddr
        //   we     reg  data          rv rdata         err done cnt
        add(32'h0301_0001, 32'hDEAD_BEEF, 0, 32'h0,
            4'b0010, 3, 32'hDEAD_BEEF, 0, 32'h0, 0, 0, 1);
        add(32'h0000_0002, 32'h0000_1111, 0, 32'h0,
            4'b0000, 3, 32'hDEAD_BEEF, 0, 32'h0, 0, 0, 1);
        add(32'h0004_0001, 32'h0000_2222, 0, 32'h0,
            4'b0000, 3, 32'hDEAD_BEEF, 0, 32'h0, 0, 0, 1);
        add(32'h0800_0001, 32'h0000_3333, 0, 32'h0,
            4'b0000, 3, 32'hDEAD_BEEF, 0, 32'h0, 0, 0, 1);
        add(32'h0, 32'h0, 1, 32'h0301_0001,
            4'b0000, 3, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 0, 0, 1);
        add(32'h0, 32'h0, 1, 32'h0000_0005,
            4'b0000, 3, 32'hDEAD_BEEF, 1, 32'h0, 1, 0, 1);
        add(32'h0000_0001, 32'h0000_0001, 1, 32'h0000_0001,
            4'b0001, 0, 32'h0000_0001, 1, 32'h0, 0, 0, 2);
        add(32'h0102_0001, 32'h0000_AAAA, 1, 32'h0000_0001,
            4'b0100, 1, 32'h0000_AAAA, 1, 32'h1, 0, 0, 3);
        add(32'h0703_0001, 32'h0000_BBBB, 0, 32'h0,
            4'b1000, 7, 32'h0000_BBBB, 0, 32'h0, 0, 0, 4);
        add(32'h0, 32'h0, 0, 32'h0,
            4'b0000, 7, 32'h0000_BBBB, 0, 32'h0, 0, 0, 4);
        add(32'h0, 32'h0, 0, 32'h0,
            4'b0000, 7, 32'h0000_BBBB, 0, 32'h0, 0, 0, 4);
        add(32'h0, 32'h0, 0, 32'h0,
            4'b0000, 7, 32'h0000_BBBB, 0, 32'h0, 0, 0, 4);
        add(32'h0, 32'h0, 0, 32'h0,
            4'b0000, 7, 32'h0000_BBBB, 0, 32'h0, 0, 1, 4);
        add(32'h0, 32'h0, 0, 32'h0,
            4'b0000, 7, 32'h0000_BBBB, 0, 32'h0, 0, 1, 4);
        add(32'h0000_0001, 32'h0000_0005, 0, 32'h0,
            4'b0001, 0, 32'h0000_0005, 0, 32'h0, 0, 0, 5);
        add(32'h0, 32'h0, 1, 32'h0703_0001,
            4'b0000, 0, 32'h0000_0005, 1, 32'h0000_BBBB, 0, 0, 5);
        add(32'h0, 32'h0, 1, 32'h0004_0001,
            4'b0000, 0, 32'h0000_0005, 1, 32'h0, 1, 0, 5);

        reset_in = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(negedge clk_in);
        check("reset", zero_e);
        reset_in = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].addr, vecs[i].data, vecs[i].rreq, vecs[i].raddr);
            sb.push_back(vecs[i].e);
            sb_id.push_back(i);
            @(negedge clk_in);
            if (sb.size() == 2) begin
                e = sb.pop_front();
                check($sformatf("vec%0d", sb_id.pop_front()), e);
            end
        end
        drive(32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk_in);
        e = sb.pop_front();
        check($sformatf("vec%0d", sb_id.pop_front()), e);

        // Reset lands while a hit word sits in stage 1
        drive(32'h0000_0001, 32'h0000_0077, 1'b0, 32'h0);
        @(negedge clk_in);
        reset_in = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk_in);
        check("rst_mid", zero_e);
        reset_in = 1'b0;
        @(negedge clk_in);
        check("rst_after", zero_e);
        drive(32'h0, 32'h0, 1'b1, 32'h0000_0001);
        @(negedge clk_in);
        drive(32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk_in);
        e = zero_e;
        e.rv = 1'b1;
        check("rst_rf", e);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
